// File: rtl/sdr_cpu_arbiter.sv
// sdr_cpu_arbiter
// Two-client arbiter in front of the toggle-handshake SDRAM channel that
// serves 68000 ROM/work-RAM. Client 0 is the 68k bus and client 1 is the
// save-state dump/restore bus. One transaction is in flight downstream at a
// time. A watchdog force-completes a stalled transaction so DTACK never hangs.
module sdr_cpu_arbiter #(
    parameter int unsigned TIMEOUT    = 1023, // WAIT cycles before force-completion (2..65535)
    parameter int unsigned FIXED_PRIO = 0     // 0 = round-robin, 1 = client 0 wins ties
) (
    input  logic        clk,
    input  logic        reset,

    // client 0: 68000 bus
    input  logic [31:0] c0_addr,
    input  logic [15:0] c0_data,
    input  logic [1:0]  c0_be,
    input  logic        c0_rw,
    input  logic        c0_req,
    output logic        c0_ack,
    output logic [15:0] c0_q,

    // client 1: save-state bus
    input  logic [31:0] c1_addr,
    input  logic [15:0] c1_data,
    input  logic [1:0]  c1_be,
    input  logic        c1_rw,
    input  logic        c1_req,
    output logic        c1_ack,
    output logic [15:0] c1_q,

    // downstream SDRAM channel
    output logic [31:0] sdr_addr,
    output logic [15:0] sdr_data,
    output logic [1:0]  sdr_be,
    output logic        sdr_rw,
    output logic        sdr_req,
    input  logic        sdr_ack,
    input  logic [15:0] sdr_q,

    // status
    output logic        grant,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE,   // waiting for a pending client request
        ST_WAIT,   // transaction issued, waiting for sdr_ack
        ST_DRAIN   // watchdog fired; waiting for the late sdr_ack to arrive
    } state_t;

    // The watchdog value on the edge that expires it (the TIMEOUT-th WAIT edge).
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] watchdog;

    logic        pend0;
    logic        pend1;
    logic        sdr_done;
    logic        pick;

    logic [31:0] sel_addr;
    logic [15:0] sel_data;
    logic [1:0]  sel_be;
    logic        sel_rw;

    // A toggle handshake is pending while the two sides of it disagree.
    assign pend0    = (c0_req != c0_ack);
    assign pend1    = (c1_req != c1_ack);
    assign sdr_done = (sdr_ack == sdr_req);

    // Choose which client is served next when the FSM is idle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        pick = 1'b0;
        if (pend0 && pend1) begin
            // Round-robin favours whoever was not served last; grant resets to 1
            // so the 68k wins the very first contention.
            pick = (FIXED_PRIO != 0) ? 1'b0 : ~grant;
        end else if (pend1) begin
            pick = 1'b1;
        end
    end

    // Request fields of the selected client, captured only on the issuing edge.
    assign sel_addr = pick ? c1_addr : c0_addr;
    assign sel_data = pick ? c1_data : c0_data;
    assign sel_be   = pick ? c1_be   : c0_be;
    assign sel_rw   = pick ? c1_rw   : c0_rw;

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state       <= ST_IDLE;
            watchdog    <= '0;
            sdr_addr    <= '0;
            sdr_data    <= '0;
            sdr_be      <= '0;
            sdr_rw      <= 1'b1;
            // Equalise every toggle pair so nothing looks pending after reset;
            // an in-flight transaction is abandoned without a client ack.
            sdr_req     <= sdr_ack;
            c0_ack      <= c0_req;
            c1_ack      <= c1_req;
            c0_q        <= '0;
            c1_q        <= '0;
            grant       <= 1'b1;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pend0 || pend1) begin
                        sdr_addr <= sel_addr;
                        sdr_data <= sel_data;
                        sdr_be   <= sel_be;
                        sdr_rw   <= sel_rw;
                        sdr_req  <= ~sdr_req;
                        grant    <= pick;
                        watchdog <= '0;
                        busy     <= 1'b1;
                        state    <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    watchdog <= watchdog + 16'd1;
                    // A real ack beats a watchdog expiry on the same edge.
                    if (sdr_done) begin
                        if (grant) begin
                            if (sdr_rw) begin
                                c1_q <= sdr_q;
                            end
                            c1_ack <= ~c1_ack;
                        end else begin
                            if (sdr_rw) begin
                                c0_q <= sdr_q;
                            end
                            c0_ack <= ~c0_ack;
                        end
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (watchdog == WD_LAST) begin
                        // Release the client with all-ones data; the downstream
                        // transaction is still outstanding, so drain it first.
                        if (grant) begin
                            c1_q   <= 16'hffff;
                            c1_ack <= ~c1_ack;
                        end else begin
                            c0_q   <= 16'hffff;
                            c0_ack <= ~c0_ack;
                        end
                        timeout_err <= 1'b1;
                        state       <= ST_DRAIN;
                    end
                end

                ST_DRAIN: begin
                    // No new issue until the channel's toggle pair is equal again.
                    if (sdr_done) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdr_cpu_arbiter.sv
// Self-checking bench for sdr_cpu_arbiter.
// Main instance: TIMEOUT=16, round-robin, driven by a behavioural SDRAM
// responder with programmable latency. Expected issues and completions are
// queued when stimulus is driven and popped when the DUT produces them.
// Second instance: FIXED_PRIO=1 with a one-cycle responder, grant order checked.
module tb_sdr_cpu_arbiter;

    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;

    // main instance
    logic [31:0] c0_addr = '0, c1_addr = '0;
    logic [15:0] c0_data = '0, c1_data = '0;
    logic [1:0]  c0_be = '0, c1_be = '0;
    logic        c0_rw = 1'b1, c1_rw = 1'b1;
    logic        c0_req = 1'b1, c1_req = 1'b0;
    logic        c0_ack, c1_ack;
    logic [15:0] c0_q, c1_q;
    logic [31:0] sdr_addr;
    logic [15:0] sdr_data;
    logic [1:0]  sdr_be;
    logic        sdr_rw, sdr_req;
    logic        sdr_ack = 1'b1;
    logic [15:0] sdr_q = '0;
    logic        grant, busy, timeout_err;

    // fixed-priority instance (shares the client request fields)
    logic        fp_c0_req = 1'b0, fp_c1_req = 1'b0;
    logic        fp_c0_ack, fp_c1_ack;
    logic [15:0] fp_c0_q, fp_c1_q;
    logic [31:0] fp_sdr_addr;
    logic [15:0] fp_sdr_data;
    logic [1:0]  fp_sdr_be;
    logic        fp_sdr_rw, fp_sdr_req;
    logic        fp_sdr_ack = 1'b0;
    logic [15:0] fp_sdr_q = 16'h0;
    logic        fp_grant, fp_busy, fp_timeout_err;

    sdr_cpu_arbiter #(.TIMEOUT(TO), .FIXED_PRIO(0)) dut (
        .clk(clk), .reset(reset),
        .c0_addr(c0_addr), .c0_data(c0_data), .c0_be(c0_be), .c0_rw(c0_rw),
        .c0_req(c0_req), .c0_ack(c0_ack), .c0_q(c0_q),
        .c1_addr(c1_addr), .c1_data(c1_data), .c1_be(c1_be), .c1_rw(c1_rw),
        .c1_req(c1_req), .c1_ack(c1_ack), .c1_q(c1_q),
        .sdr_addr(sdr_addr), .sdr_data(sdr_data), .sdr_be(sdr_be), .sdr_rw(sdr_rw),
        .sdr_req(sdr_req), .sdr_ack(sdr_ack), .sdr_q(sdr_q),
        .grant(grant), .busy(busy), .timeout_err(timeout_err)
    );

    sdr_cpu_arbiter #(.TIMEOUT(TO), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .reset(reset),
        .c0_addr(c0_addr), .c0_data(c0_data), .c0_be(c0_be), .c0_rw(c0_rw),
        .c0_req(fp_c0_req), .c0_ack(fp_c0_ack), .c0_q(fp_c0_q),
        .c1_addr(c1_addr), .c1_data(c1_data), .c1_be(c1_be), .c1_rw(c1_rw),
        .c1_req(fp_c1_req), .c1_ack(fp_c1_ack), .c1_q(fp_c1_q),
        .sdr_addr(fp_sdr_addr), .sdr_data(fp_sdr_data), .sdr_be(fp_sdr_be), .sdr_rw(fp_sdr_rw),
        .sdr_req(fp_sdr_req), .sdr_ack(fp_sdr_ack), .sdr_q(fp_sdr_q),
        .grant(fp_grant), .busy(fp_busy), .timeout_err(fp_timeout_err)
    );

    typedef struct {
        logic        client;
        logic [31:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
        logic        rw;
        logic [15:0] rdata;   // value the responder returns on sdr_q
    } issue_t;

    typedef struct {
        logic        client;
        logic [15:0] q;
        bit          timed_out;
    } done_t;

    issue_t      exp_issue[$];
    done_t       exp_done[$];
    logic        fp_exp_grant[$];
    logic [15:0] shadow_q[2];

    int n_tests = 0;
    int n_fail  = 0;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // responder state
    int unsigned ds_latency = 1;
    bit          ds_hold = 1'b0;
    bit          ds_busy = 1'b0;
    int unsigned ds_cnt = 0;
    int unsigned ds_issue_cyc = 0, prev_issue_cyc = 0, ds_ack_cyc = 0, ds_n_issue = 0;
    logic [15:0] ds_rdata = '0;
    logic        prev_c0_ack = 1'b0, prev_c1_ack = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_issue(input logic client, input logic [31:0] addr, input logic [15:0] data,
                              input logic [1:0] be, input logic rw, input logic [15:0] rdata);
        issue_t it;
        it.client = client;
        it.addr   = addr;
        it.data   = data;
        it.be     = be;
        it.rw     = rw;
        it.rdata  = rdata;
        exp_issue.push_back(it);
    endtask

    task automatic push_done(input logic client, input logic [15:0] q, input bit timed_out);
        done_t dt;
        dt.client    = client;
        dt.q         = q;
        dt.timed_out = timed_out;
        exp_done.push_back(dt);
        shadow_q[client] = q;
    endtask

    // A normal transaction: reads return rdata, writes leave the client's q alone.
    task automatic expect_txn(input logic client, input logic [31:0] addr, input logic [15:0] data,
                              input logic [1:0] be, input logic rw, input logic [15:0] rdata);
        push_issue(client, addr, data, be, rw, rdata);
        push_done(client, rw ? rdata : shadow_q[client], 1'b0);
    endtask

    task automatic drive(input logic client, input logic [31:0] addr, input logic [15:0] data,
                         input logic [1:0] be, input logic rw);
        if (client == 1'b0) begin
            c0_addr = addr; c0_data = data; c0_be = be; c0_rw = rw;
            c0_req  = ~c0_req;
        end else begin
            c1_addr = addr; c1_data = data; c1_be = be; c1_rw = rw;
            c1_req  = ~c1_req;
        end
    endtask

    task automatic on_issue();
        issue_t it;
        ds_n_issue++;
        prev_issue_cyc = ds_issue_cyc;
        ds_issue_cyc   = cyc;
        check("issue_expected", 32'(exp_issue.size() != 0), 32'd1);
        if (exp_issue.size() != 0) begin
            it = exp_issue.pop_front();
            check("issue_grant", 32'(grant), 32'(it.client));
            check("issue_addr", sdr_addr, it.addr);
            check("issue_rw", 32'(sdr_rw), 32'(it.rw));
            check("issue_be", 32'(sdr_be), 32'(it.be));
            if (!it.rw) check("issue_data", 32'(sdr_data), 32'(it.data));
            check("issue_busy", 32'(busy), 32'd1);
            ds_rdata = it.rdata;
        end else begin
            ds_rdata = 16'h0;
        end
    endtask

    task automatic on_done(input logic client);
        done_t dt;
        check("done_expected", 32'(exp_done.size() != 0), 32'd1);
        if (exp_done.size() != 0) begin
            dt = exp_done.pop_front();
            check("done_client", 32'(client), 32'(dt.client));
            if (client == 1'b0) begin
                check("c0_q", 32'(c0_q), 32'(dt.q));
                check("c0_ack_eq_req", 32'(c0_ack == c0_req), 32'd1);
            end else begin
                check("c1_q", 32'(c1_q), 32'(dt.q));
                check("c1_ack_eq_req", 32'(c1_ack == c1_req), 32'd1);
            end
            if (dt.timed_out) begin
                check("timeout_latency", cyc - ds_issue_cyc, 32'(TO));
                check("timeout_err_set", 32'(timeout_err), 32'd1);
            end else begin
                check("done_latency", cyc - ds_ack_cyc, 32'd1);
            end
        end
    endtask

    task automatic on_fp_issue();
        logic g;
        check("fp_issue_expected", 32'(fp_exp_grant.size() != 0), 32'd1);
        if (fp_exp_grant.size() != 0) begin
            g = fp_exp_grant.pop_front();
            check("fp_grant", 32'(fp_grant), 32'(g));
        end
    endtask

    // Monitors and SDRAM responders, all acting on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            prev_c0_ack = c0_ack;
            prev_c1_ack = c1_ack;
            ds_busy     = 1'b0;
        end else begin
            if (c0_ack != prev_c0_ack) on_done(1'b0);
            if (c1_ack != prev_c1_ack) on_done(1'b1);
            prev_c0_ack = c0_ack;
            prev_c1_ack = c1_ack;

            if (!ds_busy && (sdr_req != sdr_ack)) begin
                on_issue();
                ds_busy = 1'b1;
                ds_cnt  = 0;
            end
            // Latency L: sdr_ack is sampled by the DUT L edges after the issuing edge.
            if (ds_busy && !ds_hold) begin
                ds_cnt++;
                if (ds_cnt >= ds_latency) begin
                    sdr_q      = ds_rdata;
                    sdr_ack    = ~sdr_ack;
                    ds_busy    = 1'b0;
                    ds_ack_cyc = cyc;
                end
            end

            if (fp_sdr_req != fp_sdr_ack) begin
                on_fp_issue();
                fp_sdr_ack = fp_sdr_req;
            end
        end
    end

    task automatic wait_idle(input string tag, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (exp_done.size() == 0 && c0_ack == c0_req && c1_ack == c1_req && !busy) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_issue(input string tag, input int unsigned target, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (ds_n_issue == target) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_c0_acked(input string tag, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (c0_ack == c0_req) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit reached");
    end

    initial begin
        int unsigned n0;
        bit ok;
        shadow_q[0] = '0;
        shadow_q[1] = '0;

        // ---- reset values (c0_req=1, sdr_ack=1 while in reset) ----
        tick(3);
        check("rst_c0_ack", 32'(c0_ack), 32'd1);
        check("rst_c1_ack", 32'(c1_ack), 32'd0);
        check("rst_sdr_req", 32'(sdr_req), 32'd1);
        check("rst_sdr_addr", sdr_addr, 32'h0);
        check("rst_sdr_data", 32'(sdr_data), 32'h0);
        check("rst_sdr_be", 32'(sdr_be), 32'h0);
        check("rst_sdr_rw", 32'(sdr_rw), 32'd1);
        check("rst_c0_q", 32'(c0_q), 32'h0);
        check("rst_c1_q", 32'(c1_q), 32'h0);
        check("rst_grant", 32'(grant), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        reset = 1'b0;
        tick(2);
        check("no_spurious_issue", 32'(sdr_req), 32'(sdr_ack));

        // ---- single read from c0 ----
        ds_latency = 5;
        expect_txn(1'b0, 32'h0000_0100, 16'h0000, 2'b11, 1'b1, 16'hBEEF);
        drive(1'b0, 32'h0000_0100, 16'h0000, 2'b11, 1'b1);
        tick(1);
        check("issue_latency", 32'(sdr_req != sdr_ack), 32'd1);
        wait_idle("single_read_idle", 40);
        check("single_read_q", 32'(c0_q), 32'hBEEF);
        check("single_read_c1_q", 32'(c1_q), 32'h0);
        check("single_read_c1_ack", 32'(c1_ack == c1_req), 32'd1);

        // ---- c1 read, then c1 write that must not touch c1_q ----
        ds_latency = 2;
        expect_txn(1'b1, 32'h0000_2000, 16'h0000, 2'b11, 1'b1, 16'h5555);
        drive(1'b1, 32'h0000_2000, 16'h0000, 2'b11, 1'b1);
        wait_idle("c1_read_idle", 40);
        ds_latency = 3;
        expect_txn(1'b1, 32'h0010_0040, 16'h1234, 2'b10, 1'b0, 16'hDEAD);
        drive(1'b1, 32'h0010_0040, 16'h1234, 2'b10, 1'b0);
        wait_idle("c1_write_idle", 40);
        check("write_keeps_c1_q", 32'(c1_q), 32'h5555);

        // ---- round-robin contention: order 0,1 per round after a c1 grant ----
        for (int r = 0; r < 3; r++) begin
            ds_latency = 32'(r + 1);
            expect_txn(1'b0, 32'h0000_3000 + 32'(r * 4), 16'h0000, 2'b11, 1'b1, 16'hA000 + 16'(r));
            expect_txn(1'b1, 32'h0000_4000 + 32'(r * 4), 16'h7000 + 16'(r), 2'b01, 1'b0, 16'h0000);
            drive(1'b0, 32'h0000_3000 + 32'(r * 4), 16'h0000, 2'b11, 1'b1);
            drive(1'b1, 32'h0000_4000 + 32'(r * 4), 16'h7000 + 16'(r), 2'b01, 1'b0);
            wait_idle("rr_idle", 60);
            // ack sampled L edges after issue, next issue one edge later
            check("rr_issue_spacing", ds_issue_cyc - prev_issue_cyc, 32'(r + 2));
        end

        // ---- watchdog expiry, then drain before the next issue ----
        ds_hold = 1'b1;
        push_issue(1'b0, 32'h0000_5000, 16'h0000, 2'b11, 1'b1, 16'h0000);
        push_done(1'b0, 16'hFFFF, 1'b1);
        drive(1'b0, 32'h0000_5000, 16'h0000, 2'b11, 1'b1);
        wait_c0_acked("timeout_ack", 40);
        check("timeout_q", 32'(c0_q), 32'hFFFF);
        check("timeout_err", 32'(timeout_err), 32'd1);
        check("drain_busy", 32'(busy), 32'd1);
        n0 = ds_n_issue;
        expect_txn(1'b1, 32'h0000_6000, 16'h0000, 2'b11, 1'b1, 16'h6666);
        drive(1'b1, 32'h0000_6000, 16'h0000, 2'b11, 1'b1);
        tick(5);
        check("drain_no_issue", ds_n_issue, n0);
        check("drain_sdr_addr", sdr_addr, 32'h0000_5000);
        ds_latency = 4;
        ds_hold    = 1'b0;
        wait_issue("drain_reissue", n0 + 1, 20);
        check("drain_reissue_latency", ds_issue_cyc - ds_ack_cyc, 32'd2);
        wait_idle("after_drain_idle", 40);
        check("timeout_err_sticky", 32'(timeout_err), 32'd1);

        // ---- reset in the middle of WAIT ----
        ds_hold = 1'b1;
        n0 = ds_n_issue;
        push_issue(1'b0, 32'h0000_7000, 16'h0000, 2'b11, 1'b1, 16'h0000);
        drive(1'b0, 32'h0000_7000, 16'h0000, 2'b11, 1'b1);
        wait_issue("rstw_issue", n0 + 1, 10);
        tick(3);
        check("rstw_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        tick(2);
        reset   = 1'b0;
        ds_hold = 1'b0;
        shadow_q[0] = '0;
        shadow_q[1] = '0;
        check("rstw_sdr_sync", 32'(sdr_req), 32'(sdr_ack));
        check("rstw_c0_ack", 32'(c0_ack), 32'(c0_req));
        check("rstw_c1_ack", 32'(c1_ack), 32'(c1_req));
        check("rstw_busy", 32'(busy), 32'd0);
        check("rstw_timeout_err", 32'(timeout_err), 32'd0);
        check("rstw_grant", 32'(grant), 32'd1);
        check("rstw_c0_q", 32'(c0_q), 32'h0);
        n0 = ds_n_issue;
        tick(20);
        check("rstw_no_reissue", ds_n_issue, n0);
        check("rstw_no_stale_ack", 32'(c0_ack), 32'(c0_req));

        // ---- contention right after reset: client 0 first ----
        ds_latency = 2;
        expect_txn(1'b0, 32'h0000_9000, 16'h0000, 2'b11, 1'b1, 16'h9999);
        expect_txn(1'b1, 32'h0000_9100, 16'h4321, 2'b11, 1'b0, 16'h0000);
        drive(1'b0, 32'h0000_9000, 16'h0000, 2'b11, 1'b1);
        drive(1'b1, 32'h0000_9100, 16'h4321, 2'b11, 1'b0);
        wait_idle("post_reset_rr_idle", 40);
        check("post_reset_c1_q", 32'(c1_q), 32'h0);

        // ---- ack arriving on the watchdog expiry edge wins ----
        ds_latency = TO;
        expect_txn(1'b0, 32'h0000_8000, 16'h0000, 2'b11, 1'b1, 16'hCAFE);
        drive(1'b0, 32'h0000_8000, 16'h0000, 2'b11, 1'b1);
        wait_idle("expiry_edge_idle", 60);
        check("expiry_edge_q", 32'(c0_q), 32'hCAFE);
        check("expiry_edge_no_err", 32'(timeout_err), 32'd0);

        // ---- fixed priority: c0 re-requests immediately, c1 waits ----
        fp_exp_grant.push_back(1'b0);
        fp_exp_grant.push_back(1'b0);
        fp_exp_grant.push_back(1'b0);
        fp_exp_grant.push_back(1'b0);
        fp_exp_grant.push_back(1'b1);
        fp_c0_req = ~fp_c0_req;
        fp_c1_req = ~fp_c1_req;
        for (int k = 0; k < 3; k++) begin
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                tick(1);
                if (fp_c0_ack == fp_c0_req) begin
                    ok = 1'b1;
                    break;
                end
            end
            check("fp_c0_served", 32'(ok), 32'd1);
            check("fp_c1_still_waiting", 32'(fp_c1_ack != fp_c1_req), 32'd1);
            fp_c0_req = ~fp_c0_req;
        end
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (fp_c0_ack == fp_c0_req && fp_c1_ack == fp_c1_req && fp_exp_grant.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("fp_all_served", 32'(ok), 32'd1);
        check("fp_last_grant", 32'(fp_grant), 32'd1);

        tick(3);
        check("issue_queue_empty", 32'(exp_issue.size()), 32'd0);
        check("done_queue_empty", 32'(exp_done.size()), 32'd0);
        check("fp_queue_empty", 32'(fp_exp_grant.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
